// File: rtl/db_qp_index_pkg.sv
// db_qp_index_pkg: shared constants, edge encodings and FSM states for the deblocking QP index stage
package db_qp_index_pkg;
    localparam int QP_MAX = 51;
    localparam logic [2:0] E_LEFT        = 3'd0;
    localparam logic [2:0] E_V_LAST      = 3'd3;
    localparam logic [2:0] E_TOP         = 3'd4;
    localparam logic [2:0] E_LUMA_LAST   = 3'd7;
    localparam logic [2:0] E_C_MID       = 3'd2;
    localparam logic [2:0] E_CHROMA_LAST = 3'd6;
    typedef enum logic [1:0] {S_IDLE, S_EDGE, S_DONE} state_t;
endpackage

// File: rtl/db_qpc_map.sv
// db_qpc_map: combinational qPi -> QPc chroma QP mapping table
module db_qpc_map (
    input  logic [5:0] qpi,
    output logic [5:0] qpc
);
    localparam logic [5:0] TBL [32] = '{
        6'd29, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33, 6'd34, 6'd34,
        6'd35, 6'd35, 6'd36, 6'd36, 6'd37, 6'd37, 6'd37, 6'd38,
        6'd38, 6'd38, 6'd39, 6'd39, 6'd39, 6'd39, 6'd39, 6'd39,
        6'd39, 6'd39, 6'd39, 6'd39, 6'd39, 6'd39, 6'd39, 6'd39
    };
    logic [4:0] i;
    assign i   = 5'(qpi - 6'd30);
    assign qpc = qpi < 6'd30 ? qpi : TBL[i];
endmodule

// File: rtl/db_qp_index.sv
// db_qp_index: walks the macroblock edges and emits per-edge qPav and clipped indexA/indexB; DB_CHROMA_QP_EN adds chroma edges
module db_qp_index
    import db_qp_index_pkg::*;
#(
    parameter int QP_W  = 6,
    parameter int OFS_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [QP_W-1:0]  mb_qp_i,
    input  logic [QP_W-1:0]  left_qp_i,
    input  logic [QP_W-1:0]  top_qp_i,
    input  logic             left_en_i,
    input  logic             top_en_i,
    input  logic [OFS_W-1:0] ofs_a_i,
    input  logic [OFS_W-1:0] ofs_b_i,
`ifdef DB_CHROMA_QP_EN
    input  logic [OFS_W-1:0] chroma_ofs_i,
    output logic             plane_o,
`endif
    input  logic             edge_ready_i,
    output logic             edge_valid_o,
    output logic [2:0]       edge_idx_o,
    output logic [QP_W-1:0]  qp_av_o,
    output logic [QP_W-1:0]  index_a_o,
    output logic [QP_W-1:0]  index_b_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam logic [QP_W-1:0] QMAX = QP_W'(QP_MAX);
    localparam logic signed [QP_W+1:0] QMAX_S = {2'b00, QMAX};

    function automatic logic [QP_W-1:0] clip_idx(input logic [QP_W-1:0] q, input logic [OFS_W-1:0] o);
        logic signed [QP_W+1:0] s;
        s = $signed({2'b00, q}) + $signed({{(QP_W+2-OFS_W){o[OFS_W-1]}}, o});
        return s[QP_W+1] ? {QP_W{1'b0}} : (s > QMAX_S ? QMAX : s[QP_W-1:0]);
    endfunction

    function automatic logic [QP_W-1:0] avg(input logic [QP_W-1:0] a, input logic [QP_W-1:0] b);
        logic [QP_W:0] t;
        t = {1'b0, a} + {1'b0, b} + (QP_W+1)'(1);
        return t[QP_W:1];
    endfunction

    state_t state;
    logic [QP_W-1:0] mb_q, left_q, top_q, s_mb, s_left, s_top, b_mb, b_left, b_top, nxt_qp;
    logic [OFS_W-1:0] ofa_q, ofb_q, s_ofa, s_ofb;
    logic len_q, ten_q, s_len, s_ten, idle, cur_p, nxt_p, last, adv;
    logic [2:0] nxt_e;

    assign idle   = state == S_IDLE;
    assign s_mb   = idle ? mb_qp_i : mb_q;
    assign s_left = idle ? left_qp_i : left_q;
    assign s_top  = idle ? top_qp_i : top_q;
    assign s_len  = idle ? left_en_i : len_q;
    assign s_ten  = idle ? top_en_i : ten_q;
    assign s_ofa  = idle ? ofs_a_i : ofa_q;
    assign s_ofb  = idle ? ofs_b_i : ofb_q;

`ifdef DB_CHROMA_QP_EN
    logic [OFS_W-1:0] cofs_q, s_cofs;
    logic [QP_W-1:0] c_mb, c_left, c_top;
    assign s_cofs = idle ? chroma_ofs_i : cofs_q;
    assign cur_p  = plane_o;
    db_qpc_map u_map_mb   (.qpi(clip_idx(s_mb, s_cofs)),   .qpc(c_mb));
    db_qpc_map u_map_left (.qpi(clip_idx(s_left, s_cofs)), .qpc(c_left));
    db_qpc_map u_map_top  (.qpi(clip_idx(s_top, s_cofs)),  .qpc(c_top));
    assign b_mb   = nxt_p ? c_mb : s_mb;
    assign b_left = nxt_p ? c_left : s_left;
    assign b_top  = nxt_p ? c_top : s_top;
`else
    assign cur_p  = 1'b0;
    assign b_mb   = s_mb;
    assign b_left = s_left;
    assign b_top  = s_top;
`endif

    // MB edges average with the neighbour QP; internal edges use the current MB QP
    assign nxt_qp = nxt_e[1:0] != 2'd0 ? b_mb : avg(nxt_e[2] ? b_top : b_left, b_mb);
    assign adv    = (idle && start_i) || (state == S_EDGE && edge_valid_o && edge_ready_i && !last);

    // Choose the next edge: first enabled edge on start, otherwise the successor of the current edge
    always_comb begin
        last  = 1'b0;
        nxt_p = cur_p;
        nxt_e = 3'(edge_idx_o + 3'd1);
        if (idle) begin
            nxt_p = 1'b0;
            nxt_e = s_len ? E_LEFT : 3'd1;
        end else if (cur_p) begin
            last  = edge_idx_o == E_CHROMA_LAST;
            nxt_e = (edge_idx_o == E_C_MID && !s_ten) ? E_CHROMA_LAST : 3'(edge_idx_o + 3'd2);
        end else if (edge_idx_o == E_V_LAST) begin
            nxt_e = s_ten ? E_TOP : 3'd5;
        end else if (edge_idx_o == E_LUMA_LAST) begin
`ifdef DB_CHROMA_QP_EN
            nxt_p = 1'b1;
            nxt_e = s_len ? E_LEFT : E_C_MID;
`else
            last  = 1'b1;
`endif
        end
    end

    // Capture the MB parameters when a start is accepted; they stay frozen for the whole MB
    always_ff @(posedge clk) begin
        if (idle && start_i) begin
            mb_q   <= mb_qp_i;
            left_q <= left_qp_i;
            top_q  <= top_qp_i;
            len_q  <= left_en_i;
            ten_q  <= top_en_i;
            ofa_q  <= ofs_a_i;
            ofb_q  <= ofs_b_i;
`ifdef DB_CHROMA_QP_EN
            cofs_q <= chroma_ofs_i;
`endif
        end
    end

    // Sequencer FSM with registered edge outputs, advanced on each handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            edge_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            edge_idx_o   <= '0;
            qp_av_o      <= '0;
            index_a_o    <= '0;
            index_b_o    <= '0;
`ifdef DB_CHROMA_QP_EN
            plane_o      <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: if (start_i) begin
                    state  <= S_EDGE;
                    busy_o <= 1'b1;
                end
                S_EDGE: if (edge_valid_o && edge_ready_i && last) begin
                    state        <= S_DONE;
                    edge_valid_o <= 1'b0;
                    done_o       <= 1'b1;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
            if (adv) begin
                edge_valid_o <= 1'b1;
                edge_idx_o   <= nxt_e;
                qp_av_o      <= nxt_qp;
                index_a_o    <= clip_idx(nxt_qp, s_ofa);
                index_b_o    <= clip_idx(nxt_qp, s_ofb);
`ifdef DB_CHROMA_QP_EN
                plane_o      <= nxt_p;
`endif
            end
        end
    end
endmodule

// File: tb/tb_db_qp_index.sv
// tb_db_qp_index: randomized scoreboard bench for db_qp_index against an edge-list reference model
module tb_db_qp_index;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic [5:0] mb_qp_i = '0, left_qp_i = '0, top_qp_i = '0;
    logic left_en_i = 1'b0, top_en_i = 1'b0;
    logic [4:0] ofs_a_i = '0, ofs_b_i = '0;
    logic edge_ready_i = 1'b0;
    logic edge_valid_o, busy_o, done_o;
    logic [2:0] edge_idx_o;
    logic [5:0] qp_av_o, index_a_o, index_b_o;
`ifdef DB_CHROMA_QP_EN
    logic [4:0] chroma_ofs_i = '0;
    logic plane_o;
`endif

    db_qp_index dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .mb_qp_i(mb_qp_i), .left_qp_i(left_qp_i), .top_qp_i(top_qp_i),
        .left_en_i(left_en_i), .top_en_i(top_en_i),
        .ofs_a_i(ofs_a_i), .ofs_b_i(ofs_b_i),
`ifdef DB_CHROMA_QP_EN
        .chroma_ofs_i(chroma_ofs_i), .plane_o(plane_o),
`endif
        .edge_ready_i(edge_ready_i), .edge_valid_o(edge_valid_o),
        .edge_idx_o(edge_idx_o), .qp_av_o(qp_av_o),
        .index_a_o(index_a_o), .index_b_o(index_b_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit d;
        int e;
        int p;
        int qp;
        int ia;
        int ib;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    localparam int QPC_T [22] = '{29, 30, 31, 32, 32, 33, 34, 34, 35, 35, 36,
                                  36, 37, 37, 37, 38, 38, 38, 39, 39, 39, 39};

    function automatic int clip51(int v);
        return v < 0 ? 0 : (v > 51 ? 51 : v);
    endfunction

    function automatic int avg(int a, int b);
        return (a + b + 1) / 2;
    endfunction

    function automatic int qpc(int q);
        return q < 30 ? q : QPC_T[q - 30];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_edge(input int e, input int p, input int qp, input int oa, input int ob);
        exp_t x;
        x.d = 1'b0; x.e = e; x.p = p; x.qp = qp;
        x.ia = clip51(qp + oa);
        x.ib = clip51(qp + ob);
        sb.push_back(x);
    endtask

    // Expected edge list: luma edges 0..7 minus disabled MB edges, optional chroma edges, then done
    task automatic push_mb(input int mb, input int l, input int t, input bit le, input bit te,
                           input int oa, input int ob, input int co, output int n);
        exp_t x;
        n = 0;
        for (int e = 0; e < 8; e++) begin
            if ((e == 0 && !le) || (e == 4 && !te)) continue;
            push_edge(e, 0, e == 0 ? avg(l, mb) : (e == 4 ? avg(t, mb) : mb), oa, ob);
            n++;
        end
`ifdef DB_CHROMA_QP_EN
        for (int e = 0; e < 8; e += 2) begin
            if ((e == 0 && !le) || (e == 4 && !te)) continue;
            push_edge(e, 1, e == 0 ? avg(qpc(clip51(l + co)), qpc(clip51(mb + co))) :
                            e == 4 ? avg(qpc(clip51(t + co)), qpc(clip51(mb + co))) :
                                     qpc(clip51(mb + co)), oa, ob);
            n++;
        end
`else
        if (co != 0) n = n + 0;
`endif
        x.d = 1'b1; x.e = 0; x.p = 0; x.qp = 0; x.ia = 0; x.ib = 0;
        sb.push_back(x);
    endtask

    task automatic drive_mb(input int mb, input int l, input int t, input bit le, input bit te,
                            input int oa, input int ob, input int co);
        mb_qp_i = 6'(mb); left_qp_i = 6'(l); top_qp_i = 6'(t);
        left_en_i = le; top_en_i = te;
        ofs_a_i = 5'(oa); ofs_b_i = 5'(ob);
`ifdef DB_CHROMA_QP_EN
        chroma_ofs_i = 5'(co);
`endif
    endtask

    task automatic scramble_inputs();
        drive_mb($urandom_range(51), $urandom_range(51), $urandom_range(51), 1'($urandom),
                 1'($urandom), $urandom_range(24) - 12, $urandom_range(24) - 12, $urandom_range(24) - 12);
    endtask

    // One full MB: start, random or directed back-pressure, then check done lands right after the last edge
    task automatic run_mb(input int mb, input int l, input int t, input bit le, input bit te,
                          input int oa, input int ob, input int co, input int rdy_pct,
                          input int hold_e, input bit noise);
        int n, k, stalls, hl;
        @(posedge clk); #1;
        drive_mb(mb, l, t, le, te, oa, ob, co);
        push_mb(mb, l, t, le, te, oa, ob, co, n);
        start_i = 1'b1;
        edge_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (noise) scramble_inputs();
        chk("first_valid", edge_valid_o, 1);
        chk("busy_after_start", busy_o, 1);
        k = 1; stalls = 0; hl = 3;
        while (!done_o && k < 400) begin
            if (edge_valid_o && edge_idx_o == 3'(hold_e) && hl > 0) begin
                edge_ready_i = 1'b0;
                hl--;
            end else begin
                edge_ready_i = $urandom_range(99) < rdy_pct;
            end
            if (edge_valid_o && !edge_ready_i) stalls++;
            start_i = noise && ($urandom_range(3) == 0);
            if (start_i) scramble_inputs();
            @(posedge clk); #1;
            k++;
        end
        start_i = 1'b0;
        if (!done_o) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done_o within %0d cycles", k);
            sb.delete();
        end else begin
            chk("done_cycle", k, n + stalls + 1);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and done pulse, and checks outputs hold while stalled
    logic prev_stall = 1'b0;
    int h_idx, h_qp, h_ia, h_ib;
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("hold_valid", edge_valid_o, 1);
                chk("hold_idx", edge_idx_o, h_idx);
                chk("hold_qp", qp_av_o, h_qp);
                chk("hold_ia", index_a_o, h_ia);
                chk("hold_ib", index_b_o, h_ib);
            end
            if (edge_valid_o && edge_ready_i) begin
                total++;
                if (sb.size() == 0 || sb[0].d) begin
                    bad++;
                    $display("FAIL unexpected_edge: got edge %0d with no edge expected", edge_idx_o);
                end else begin
                    x = sb.pop_front();
                    chk("edge_idx", edge_idx_o, x.e);
                    chk("qp_av", qp_av_o, x.qp);
                    chk("index_a", index_a_o, x.ia);
                    chk("index_b", index_b_o, x.ib);
`ifdef DB_CHROMA_QP_EN
                    chk("plane", plane_o, x.p);
`endif
                end
            end
            if (done_o) begin
                total++;
                if (sb.size() == 0 || !sb[0].d) begin
                    bad++;
                    $display("FAIL done_order: got done_o with %0d edges still expected", sb.size());
                end else begin
                    x = sb.pop_front();
                end
                chk("done_valid_low", edge_valid_o, 0);
            end
            prev_stall = edge_valid_o && !edge_ready_i;
            h_idx = edge_idx_o; h_qp = qp_av_o; h_ia = index_a_o; h_ib = index_b_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", edge_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_idx", edge_idx_o, 0);
        chk("rst_qp", qp_av_o, 0);
        chk("rst_ia", index_a_o, 0);
        chk("rst_ib", index_b_o, 0);
        rst = 1'b0;
        run_mb(30, 26, 20, 1, 1, 0, 0, 0, 100, -1, 0);
        run_mb(45, 45, 45, 1, 1, 12, -12, 0, 100, -1, 0);
        run_mb(5, 5, 5, 1, 1, -12, 0, 0, 100, -1, 0);
        run_mb(17, 40, 3, 0, 0, 2, -4, 0, 100, -1, 0);
        run_mb(22, 10, 50, 1, 1, -6, 8, 0, 100, 2, 1);
        // reset during edge 5, then a clean MB starting at edge 0
        @(posedge clk); #1;
        drive_mb(33, 21, 47, 1, 1, 4, -2, 0);
        push_mb(33, 21, 47, 1, 1, 4, -2, 0, n);
        start_i = 1'b1;
        edge_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        k = 0;
        while (!(edge_valid_o && edge_idx_o == 3'd5) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_edge5", edge_idx_o, 5);
        edge_ready_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", edge_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        rst = 1'b0;
        sb.delete();
        run_mb(12, 50, 0, 1, 1, 0, 0, 0, 100, -1, 0);
`ifdef DB_CHROMA_QP_EN
        run_mb(40, 40, 40, 1, 1, 0, 0, 0, 100, -1, 0);
        run_mb(30, 30, 30, 1, 1, 0, 0, 0, 100, -1, 0);
`endif
        for (int i = 0; i < 40; i++)
            run_mb($urandom_range(51), $urandom_range(51), $urandom_range(51), 1'($urandom), 1'($urandom),
                   $urandom_range(24) - 12, $urandom_range(24) - 12, $urandom_range(24) - 12,
                   $urandom_range(40, 100), $urandom_range(8) - 1, 1);
        @(posedge clk); #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
